color_blink: RTL

Parametrised, pipelined CGA attribute-to-RGB colour stage for the text-mode path. It sits between the glyph/attribute fetch and the LCD pins, and accepts one 8-bit irgb attribute plus a pixel-on bit per clock. It emits an RGB word of configurable per-channel width after a fixed 2-cycle latency. Over the original combinational mapper it adds:
- CGA blink mode driven by a frame counter,
- cursor inversion,
- the CGA brown correction,
- blanking on data-enable.

---
 rtl/color_pkg.sv | 30 +++
 rtl/color_expand.sv | 15 +
 rtl/color_blink.sv | 129 ++++++++++++
 3 files changed

// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - attribute bit positions and irgb layout shared with the glyph/attribute path
package color_pkg;

  // Attribute byte: [7:4] background irgb, [3:0] foreground irgb
  localparam int BACK_I = 7;
  localparam int BACK_R = 6;
  localparam int BACK_G = 5;
  localparam int BACK_B = 4;
  localparam int FORE_I = 3;
  localparam int FORE_R = 2;
  localparam int FORE_G = 1;
  localparam int FORE_B = 0;

  // Bit positions inside one irgb nibble
  localparam int IRGB_I = 3;
  localparam int IRGB_R = 2;
  localparam int IRGB_G = 1;
  localparam int IRGB_B = 0;

  typedef logic [3:0] irgb_t;

  // Dark yellow, rendered as brown on a real CGA monitor
  localparam irgb_t CGA_BROWN = 4'b0110;

  // Background nibble; in blink mode the intensity bit is the blink flag, so it reads as 0
  function automatic irgb_t back_irgb(input logic [7:0] attr, input logic blink_mode);
    back_irgb = {attr[BACK_I] & ~blink_mode, attr[BACK_R], attr[BACK_G], attr[BACK_B]};
  endfunction

endpackage

// File: rtl/color_expand.sv
// rtl/color_expand.sv - expands one colour bit plus intensity into a W-bit level
module color_expand #(
  parameter int W = 5
) (
  input  logic         c,
  input  logic         i,
  output logic [W-1:0] o
);

  // MSB-first alternation c,i,c,i... gives levels 0, 0x55, 0xAA, 0xFF truncated to W bits
  for (genvar k = 0; k < W; k++) begin : g_bit
    assign o[W-1-k] = (k % 2 == 0) ? c : i;
  end

endmodule

// File: rtl/color_blink.sv
// rtl/color_blink.sv - pipelined CGA attribute-to-RGB stage with blink, cursor, brown fix and blanking
module color_blink
  import color_pkg::*;
#(
  parameter int RED_W        = 5,
  parameter int GREEN_W      = 6,
  parameter int BLUE_W       = 5,
  parameter int BLINK_FRAMES = 16,
  parameter int BROWN_FIX    = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [7:0]         i_attr,
  input  logic               i_active,
  input  logic               i_cursor,
  input  logic               i_de,
  input  logic               i_frame,
  input  logic               i_blink_mode,
  output logic [RED_W-1:0]   o_red,
  output logic [GREEN_W-1:0] o_green,
  output logic [BLUE_W-1:0]  o_blue,
  output logic               o_de,
  output logic               o_blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;
  irgb_t              irgb_q, irgb_d;
  logic               de1_q, de1_d;
  logic [RED_W-1:0]   red_q, red_d;
  logic [GREEN_W-1:0] green_q, green_d;
  logic [BLUE_W-1:0]  blue_q, blue_d;
  logic               de2_q, de2_d;

  logic               hide;
  logic               sel_fore;
  logic [RED_W-1:0]   red_x;
  logic [GREEN_W-1:0] green_x;
  logic [BLUE_W-1:0]  blue_x;

  // Blink counter: one count per frame strobe, phase toggles on wrap
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (i_frame) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Stage 1 input: pick fore or back nibble; cursor inverts after blink hiding
  always_comb begin
    hide     = i_blink_mode & i_attr[BACK_I] & phase_q;
    sel_fore = (i_active & ~hide) ^ i_cursor;
    irgb_d   = sel_fore ? i_attr[FORE_I:FORE_B] : back_irgb(i_attr, i_blink_mode);
    de1_d    = i_de;
  end

  color_expand #(.W(RED_W)) u_red (
    .c (irgb_q[IRGB_R]),
    .i (irgb_q[IRGB_I]),
    .o (red_x)
  );

  color_expand #(.W(GREEN_W)) u_green (
    .c (irgb_q[IRGB_G]),
    .i (irgb_q[IRGB_I]),
    .o (green_x)
  );

  color_expand #(.W(BLUE_W)) u_blue (
    .c (irgb_q[IRGB_B]),
    .i (irgb_q[IRGB_I]),
    .o (blue_x)
  );

  // Stage 2 input: brown correction on green, then blank everything outside display enable
  always_comb begin
    red_d   = red_x;
    green_d = green_x;
    blue_d  = blue_x;
    de2_d   = de1_q;
    if ((BROWN_FIX != 0) && (irgb_q == CGA_BROWN)) begin
      green_d = green_x >> 1;
    end
    if (!de1_q) begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
    end
  end

  // All state: blink counter and both pipeline stages, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      irgb_q  <= '0;
      de1_q   <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      de2_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      irgb_q  <= irgb_d;
      de1_q   <= de1_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      de2_q   <= de2_d;
    end
  end

  assign o_red         = red_q;
  assign o_green       = green_q;
  assign o_blue        = blue_q;
  assign o_de          = de2_q;
  assign o_blink_phase = phase_q;

endmodule
